// File: rtl/am9513_ctx_xfer_if.sv
// Signal bundle for am9513_ctx_xfer: command port, state-file port, save and restore streams.
// Define AM9513_CTX_XFER_CLEAR_EN to widen cmd_op for the save-and-clear operation.
interface am9513_ctx_xfer_if;
    logic        cmd_valid;
    logic        cmd_ready;
`ifdef AM9513_CTX_XFER_CLEAR_EN
    logic [1:0]  cmd_op;
`else
    logic        cmd_op;
`endif
    logic [15:0] cmd_ctx;

    logic [15:0] ctx_sel;
    logic [3:0]  rf_index;
    logic [1:0]  rm_rdata;
    logic [4:0]  flags_rdata;
    logic [63:0] rf_rdata;
    logic        rm_we;
    logic [1:0]  rm_wdata;
    logic        flags_clr_we;
    logic        flags_or_we;
    logic [4:0]  flags_or_mask;
    logic        rf_we;
    logic [63:0] rf_wdata;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;

    logic        done;
    logic        err;

    modport master (
        input  cmd_valid, cmd_op, cmd_ctx,
        input  rm_rdata, flags_rdata, rf_rdata,
        input  out_ready, in_valid, in_data, in_last,
        output cmd_ready, ctx_sel, rf_index,
        output rm_we, rm_wdata, flags_clr_we, flags_or_we, flags_or_mask, rf_we, rf_wdata,
        output out_valid, out_data, out_last, in_ready, done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_ctx,
        output rm_rdata, flags_rdata, rf_rdata,
        output out_ready, in_valid, in_data, in_last,
        input  cmd_ready, ctx_sel, rf_index,
        input  rm_we, rm_wdata, flags_clr_we, flags_or_we, flags_or_mask, rf_we, rf_wdata,
        input  out_valid, out_data, out_last, in_ready, done, err
    );
endinterface

// File: rtl/am9513_ctx_xfer.sv
// Am9513 context save/restore sequencer: streams one context out (save) or writes one back (restore).
// Optional AM9513_CTX_XFER_CLEAR_EN adds op 2'b10, save-and-clear.
module am9513_ctx_xfer #(
    parameter int unsigned NUM_CONTEXTS = 64,
    parameter logic [15:0] HDR_MAGIC    = 16'h9513
) (
    input  logic              clk,
    input  logic              rst_n,
    am9513_ctx_xfer_if.master bus
);

`ifdef AM9513_CTX_XFER_CLEAR_EN
    localparam logic [1:0] CARBON_RND_RN = 2'b00;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_SAVE_HDR,
        S_SAVE_REG,
        S_RST_HDR,
        S_RST_FLG,
        S_RST_REG,
        S_DRAIN,
`ifdef AM9513_CTX_XFER_CLEAR_EN
        S_CLR_HDR,
        S_CLR_REG,
`endif
        S_FIN
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_ctx;
    logic [3:0]  r_idx;
    logic [4:0]  r_beat;
    logic [4:0]  r_flags;
    logic        r_hdr_last;
    logic        r_err;
    logic        r_out_valid;
    logic [63:0] r_out_data;
`ifdef AM9513_CTX_XFER_CLEAR_EN
    logic        r_clr;
    logic        w_op_clr;
`endif

    logic        w_bad_ctx, w_op_rst, w_op_bad, w_out_hs, w_magic_ok, w_idx_last;
    logic        w_in_ready, w_rm_we, w_flags_clr_we, w_flags_or_we, w_rf_we, w_done, w_err;
    logic [1:0]  w_rm_wdata;
    logic [63:0] w_rf_wdata;

    assign w_bad_ctx  = 32'(bus.cmd_ctx) >= NUM_CONTEXTS;
`ifdef AM9513_CTX_XFER_CLEAR_EN
    assign w_op_rst   = bus.cmd_op == 2'b01;
    assign w_op_clr   = bus.cmd_op == 2'b10;
    assign w_op_bad   = bus.cmd_op == 2'b11;
`else
    assign w_op_rst   = bus.cmd_op;
    assign w_op_bad   = 1'b0;
`endif
    assign w_out_hs   = r_out_valid && bus.out_ready;
    assign w_magic_ok = bus.in_data[63:48] == HDR_MAGIC;
    assign w_idx_last = r_idx == 4'hF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_in_ready     = 1'b0;
        w_rm_we        = 1'b0;
        w_rm_wdata     = '0;
        w_flags_clr_we = 1'b0;
        w_flags_or_we  = 1'b0;
        w_rf_we        = 1'b0;
        w_rf_wdata     = '0;
        w_done         = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (w_bad_ctx || w_op_bad) w_next = S_FIN;
                    else if (w_op_rst)         w_next = S_RST_HDR;
                    else                       w_next = S_SAVE_HDR;
                end
            end
            S_SAVE_HDR: w_next = S_SAVE_REG;
            S_SAVE_REG: begin
                if (w_out_hs && r_beat == 5'd16) begin
`ifdef AM9513_CTX_XFER_CLEAR_EN
                    w_next = r_clr ? S_CLR_HDR : S_FIN;
`else
                    w_next = S_FIN;
`endif
                end
            end
            S_RST_HDR: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (w_magic_ok) begin
                        w_rm_we        = 1'b1;
                        w_rm_wdata     = bus.in_data[1:0];
                        w_flags_clr_we = 1'b1;
                        w_next         = S_RST_FLG;
                    end else begin
                        w_next = bus.in_last ? S_FIN : S_DRAIN;
                    end
                end
            end
            // OR-set lands a cycle after the clear, otherwise the clear would mask it
            S_RST_FLG: begin
                w_flags_or_we = 1'b1;
                w_next        = r_hdr_last ? S_FIN : S_RST_REG;
            end
            S_RST_REG: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = bus.in_data;
                    if (bus.in_last)     w_next = S_FIN;
                    else if (w_idx_last) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) w_next = S_FIN;
            end
`ifdef AM9513_CTX_XFER_CLEAR_EN
            S_CLR_HDR: begin
                w_rm_we        = 1'b1;
                w_rm_wdata     = CARBON_RND_RN;
                w_flags_clr_we = 1'b1;
                w_next         = S_CLR_REG;
            end
            S_CLR_REG: begin
                w_rf_we = 1'b1;
                if (w_idx_last) w_next = S_FIN;
            end
`endif
            S_FIN: begin
                w_done = 1'b1;
                w_err  = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctx       <= '0;
            r_idx       <= '0;
            r_beat      <= '0;
            r_flags     <= '0;
            r_hdr_last  <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef AM9513_CTX_XFER_CLEAR_EN
            r_clr       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_ctx      <= bus.cmd_ctx;
                        r_idx      <= '0;
                        r_beat     <= '0;
                        r_hdr_last <= 1'b0;
                        r_err      <= w_bad_ctx || w_op_bad;
`ifdef AM9513_CTX_XFER_CLEAR_EN
                        r_clr      <= w_op_clr;
`endif
                    end
                end
                // State file is addressed by r_ctx only from here on, so the header is built now
                S_SAVE_HDR: begin
                    r_out_data  <= {HDR_MAGIC, 16'h0000, r_ctx, 9'h000, bus.flags_rdata, bus.rm_rdata};
                    r_out_valid <= 1'b1;
                end
                S_SAVE_REG: begin
                    if (w_out_hs) begin
                        r_idx  <= r_idx + 4'd1;
                        r_beat <= r_beat + 5'd1;
                        if (r_beat == 5'd16) r_out_valid <= 1'b0;
                        else                 r_out_data  <= bus.rf_rdata;
                    end
                end
                S_RST_HDR: begin
                    if (bus.in_valid) begin
                        if (w_magic_ok) begin
                            r_flags    <= bus.in_data[6:2];
                            r_hdr_last <= bus.in_last;
                            r_err      <= bus.in_last;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                // Early last and missing last on reg 15 are both errors
                S_RST_REG: begin
                    if (bus.in_valid) begin
                        r_idx <= r_idx + 4'd1;
                        r_err <= bus.in_last ? !w_idx_last : w_idx_last;
                    end
                end
`ifdef AM9513_CTX_XFER_CLEAR_EN
                S_CLR_REG: r_idx <= r_idx + 4'd1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready     = r_state == S_IDLE;
    assign bus.ctx_sel       = (r_state == S_IDLE) ? '0 : r_ctx;
    assign bus.rf_index      = (r_state == S_IDLE) ? '0 : r_idx;
    assign bus.rm_we         = w_rm_we;
    assign bus.rm_wdata      = w_rm_wdata;
    assign bus.flags_clr_we  = w_flags_clr_we;
    assign bus.flags_or_we   = w_flags_or_we;
    assign bus.flags_or_mask = w_flags_or_we ? r_flags : '0;
    assign bus.rf_we         = w_rf_we;
    assign bus.rf_wdata      = w_rf_wdata;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_last      = r_out_valid && (r_beat == 5'd16);
    assign bus.in_ready      = w_in_ready;
    assign bus.done          = w_done;
    assign bus.err           = w_err;

endmodule

// File: tb/tb_am9513_ctx_xfer.sv
// Directed bench for am9513_ctx_xfer with a behavioural state-file model.
module tb_am9513_ctx_xfer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    am9513_ctx_xfer_if bus();

    am9513_ctx_xfer #(
        .NUM_CONTEXTS (64),
        .HDR_MAGIC    (16'h9513)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [1:0]  sf_rm    [64];
    logic [4:0]  sf_flags [64];
    logic [63:0] sf_rf    [64][16];
    logic        pl_go;
    logic [5:0]  pl_ctx;
    logic [1:0]  pl_rm;
    logic [4:0]  pl_flags;
    logic [63:0] pl_base;
    int unsigned wr_cnt = 0;

    assign bus.rm_rdata    = sf_rm[bus.ctx_sel[5:0]];
    assign bus.flags_rdata = sf_flags[bus.ctx_sel[5:0]];
    assign bus.rf_rdata    = sf_rf[bus.ctx_sel[5:0]][bus.rf_index];

    always @(posedge clk) begin
        if (pl_go) begin
            sf_rm[pl_ctx]    <= pl_rm;
            sf_flags[pl_ctx] <= pl_flags;
            for (int i = 0; i < 16; i++) sf_rf[pl_ctx][4'(i)] <= pl_base + 64'(i);
        end else begin
            if (bus.rm_we) sf_rm[bus.ctx_sel[5:0]] <= bus.rm_wdata;
            if (bus.flags_clr_we)     sf_flags[bus.ctx_sel[5:0]] <= 5'h00;
            else if (bus.flags_or_we) sf_flags[bus.ctx_sel[5:0]] <= sf_flags[bus.ctx_sel[5:0]] | bus.flags_or_mask;
            if (bus.rf_we) sf_rf[bus.ctx_sel[5:0]][bus.rf_index] <= bus.rf_wdata;
            if (bus.rm_we || bus.flags_clr_we || bus.flags_or_we || bus.rf_we) wr_cnt <= wr_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] ctx, input logic [1:0] rm, input logic [4:0] fl, input logic [63:0] base);
        @(negedge clk);
        pl_go = 1'b1; pl_ctx = ctx; pl_rm = rm; pl_flags = fl; pl_base = base;
        @(negedge clk);
        pl_go = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, "_ctx_sel"},   bus.ctx_sel, 16'h0);
        check({tag, "_rf_index"},  bus.rf_index, 4'h0);
        check({tag, "_we"},        {bus.rm_we, bus.flags_clr_we, bus.flags_or_we, bus.rf_we}, 4'h0);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_data"},  bus.out_data, 64'h0);
        check({tag, "_out_last"},  bus.out_last, 1'b0);
        check({tag, "_in_ready"},  bus.in_ready, 1'b0);
        check({tag, "_done_err"},  {bus.done, bus.err}, 2'b00);
    endtask

    // Saves ctx 3; stops early once abort_at beats have been accepted (abort_at < 0: full run)
    task automatic run_save(input bit stall, input int abort_at);
        int          beats = 0;
        int          cyc   = 0;
        logic [63:0] exp_d;
        int unsigned wr0;
        wr0 = wr_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_ctx = 16'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (beats < 17 && cyc < 100 && beats != abort_at) begin
            bus.out_ready = stall ? ((cyc % 2) == 1) : 1'b1;
            #1;
            if (bus.out_valid) begin
                exp_d = (beats == 0) ? 64'h9513_0000_0003_0046 : 64'hA000 + 64'(beats - 1);
                check("save_data", bus.out_data, exp_d);
                check("save_last", bus.out_last, beats == 16);
                if (bus.out_ready) beats++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (abort_at < 0) begin
            check("save_beats", beats, 17);
            #1;
            check("save_done", bus.done, 1'b1);
            check("save_err", bus.err, 1'b0);
            check("save_valid_off", bus.out_valid, 1'b0);
            check("save_no_writes", wr_cnt - wr0, 0);
            @(negedge clk);
            #1;
            check("save_idle_ready", bus.cmd_ready, 1'b1);
            check("save_done_once", bus.done, 1'b0);
        end
    endtask

    task automatic run_restore(input logic [15:0] ctx, input logic [63:0] hdr, input logic [63:0] base,
                               input int n, input bit drain_chk, input logic exp_err);
        int w;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_ctx = ctx;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int b = 0; b < n; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (b == 0) ? hdr : base + 64'(b - 1);
            bus.in_last  = (b == n - 1);
            #1;
            if (drain_chk && b > 0) check("drain_in_ready", bus.in_ready, 1'b1);
            w = 0;
            while (!bus.in_ready && w < 8) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        check("rst_done", bus.done, 1'b1);
        check("rst_err", bus.err, exp_err);
    endtask

    initial begin
        int unsigned wr0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_ctx = 16'h0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = 64'h0; bus.in_last = 1'b0;
        pl_go = 1'b0; pl_ctx = '0; pl_rm = '0; pl_flags = '0; pl_base = '0;

        preload(6'd3, 2'd2, 5'h11, 64'hA000);
        preload(6'd5, 2'd3, 5'h1F, 64'h0);
        preload(6'd6, 2'd3, 5'h1F, 64'h600);
        preload(6'd7, 2'd1, 5'h03, 64'h700);
        #1;
        check_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("post_reset");

        run_save(1'b0, -1);
        run_save(1'b1, -1);

        run_restore(16'd5, 64'h9513_0000_0005_0029, 64'hB0, 17, 1'b0, 1'b0);
        check("rst5_rm", sf_rm[5], 2'd1);
        check("rst5_flags", sf_flags[5], 5'h0A);
        for (int i = 0; i < 16; i++) check("rst5_reg", sf_rf[5][4'(i)], 64'hB0 + 64'(i));

        wr0 = wr_cnt;
        run_restore(16'd6, 64'h1234_0000_0006_0000, 64'hDEAD0, 5, 1'b1, 1'b1);
        check("badmagic_no_writes", wr_cnt - wr0, 0);
        check("badmagic_rm", sf_rm[6], 2'd3);
        check("badmagic_flags", sf_flags[6], 5'h1F);
        check("badmagic_reg0", sf_rf[6][0], 64'h600);

        run_restore(16'd7, 64'h9513_0000_0007_0000, 64'hC00, 5, 1'b0, 1'b1);
        check("early_last_rm", sf_rm[7], 2'd0);
        check("early_last_flags", sf_flags[7], 5'h00);
        check("early_last_reg3", sf_rf[7][3], 64'hC03);
        check("early_last_reg4", sf_rf[7][4], 64'h704);

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_ctx = 16'd64;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        check("reject_done_err", {bus.done, bus.err}, 2'b11);
        check("reject_no_valid", bus.out_valid, 1'b0);
        check("reject_no_we", {bus.rm_we, bus.flags_clr_we, bus.flags_or_we, bus.rf_we}, 4'h0);
        @(negedge clk);
        #1;
        check("reject_idle", bus.cmd_ready, 1'b1);
        check("reject_done_once", bus.done, 1'b0);

        run_save(1'b0, 7);
        check("abort_mid_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("abort_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
